// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one board RAM (registered address, one-cycle read latency) between the
// software host port and the hardware move engine.
//
// Arbitration: a lone requester is granted in the same cycle. When both ports
// request, the port that lost the previous contested cycle wins (round-robin).
// The engine can take back-to-back ownership with eng_lock. The burst is capped
// at MAX_LOCK grants. After that the host gets one guaranteed grant (COOLDOWN)
// before the engine can lock again.
//
// Ports
//   clk, reset                    single clock, synchronous active-high reset
//   host_* / eng_*                req, wr, addr, wdata per requester
//   eng_lock                      engine asks to keep ownership
//   host_grant / eng_grant        combinational accept strobes
//   host_rvalid / eng_rvalid      read data valid, one cycle after a read grant
//   host_rdata / eng_rdata        read data (holds between reads)
//   ram_rdaddress / ram_wraddress RAM addresses (hold when idle)
//   ram_data, ram_wren            RAM write data / enable
//   ram_q                         RAM read data
//   conflict_count                saturating count of contested cycles
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  eng_req,
    input  logic                  eng_wr,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    input  logic                  eng_lock,
    output logic                  host_grant,
    output logic                  eng_grant,
    output logic                  host_rvalid,
    output logic                  eng_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [DATA_WIDTH-1:0] eng_rdata,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [15:0]           conflict_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_COOLDOWN
    } state_t;

    localparam int CW = $clog2(MAX_LOCK + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            rr_host_q, rr_host_d;   // 1: host wins next contested cycle
    logic            host_gnt, eng_gnt;
    logic            contested;

    assign contested = host_req & eng_req;

    // -------------------------------------------------------------------------
    // Arbitration FSM: next state and grants
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        host_gnt   = 1'b0;
        eng_gnt    = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        rr_host_d  = rr_host_q;

        case (state_q)
            ST_IDLE: begin
                if (contested) begin
                    host_gnt = rr_host_q;
                    eng_gnt  = ~rr_host_q;
                end else begin
                    host_gnt = host_req;
                    eng_gnt  = eng_req;
                end
            end
            ST_LOCKED: begin
                if (eng_req) eng_gnt  = 1'b1;
                else         host_gnt = host_req;
                if (!eng_req || !eng_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    if (lock_cnt_d >= CW'(MAX_LOCK)) begin
                        state_d    = ST_COOLDOWN;
                        lock_cnt_d = '0;
                    end
                end
            end
            ST_COOLDOWN: begin
                // Host is owed one grant; with no host request the engine may go.
                if (host_req) host_gnt = 1'b1;
                else          eng_gnt  = eng_req;
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase

        // A locked engine grant from outside LOCKED starts a new burst; that
        // grant is the first of the MAX_LOCK.
        if (state_q != ST_LOCKED && eng_gnt && eng_lock) begin
            lock_cnt_d = CW'(1);
            state_d    = (MAX_LOCK <= 1) ? ST_COOLDOWN : ST_LOCKED;
        end

        // The loser of a contested cycle wins the next one.
        if (contested) rr_host_d = eng_gnt;

        if (reset) begin
            host_gnt = 1'b0;
            eng_gnt  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            rr_host_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rr_host_q  <= rr_host_d;
        end
    end

    assign host_grant = host_gnt;
    assign eng_grant  = eng_gnt;

    // -------------------------------------------------------------------------
    // RAM-side datapath
    // -------------------------------------------------------------------------
    logic                  gnt_any, sel_wr, rd_gnt, wr_gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] rdaddr_q, wraddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign gnt_any   = host_gnt | eng_gnt;
    assign sel_wr    = host_gnt ? host_wr    : eng_wr;
    assign sel_addr  = host_gnt ? host_addr  : eng_addr;
    assign sel_wdata = host_gnt ? host_wdata : eng_wdata;
    assign rd_gnt    = gnt_any & ~sel_wr;
    assign wr_gnt    = gnt_any &  sel_wr;

    // Addresses and write data hold their last granted values between accesses.
    assign ram_rdaddress = rd_gnt ? sel_addr  : rdaddr_q;
    assign ram_wraddress = wr_gnt ? sel_addr  : wraddr_q;
    assign ram_data      = wr_gnt ? sel_wdata : wdata_q;
    assign ram_wren      = wr_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdaddr_q <= '0;
            wraddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            rdaddr_q <= ram_rdaddress;
            wraddr_q <= ram_wraddress;
            wdata_q  <= ram_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read return: rvalid registered from the read grant; rdata passes ram_q
    // through in the valid cycle and holds the captured word otherwise.
    // -------------------------------------------------------------------------
    logic                  host_rvalid_q, eng_rvalid_q;
    logic [DATA_WIDTH-1:0] host_rdata_q, eng_rdata_q;

    assign host_rvalid = host_rvalid_q & ~reset;
    assign eng_rvalid  = eng_rvalid_q  & ~reset;
    assign host_rdata  = host_rvalid ? ram_q : host_rdata_q;
    assign eng_rdata   = eng_rvalid  ? ram_q : eng_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
            eng_rvalid_q  <= 1'b0;
            host_rdata_q  <= '0;
            eng_rdata_q   <= '0;
        end else begin
            host_rvalid_q <= host_gnt & ~host_wr;
            eng_rvalid_q  <= eng_gnt  & ~eng_wr;
            host_rdata_q  <= host_rdata;
            eng_rdata_q   <= eng_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Contested-cycle counter, saturating
    // -------------------------------------------------------------------------
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (contested && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Applies one vector per clock and checks grants, RAM-side outputs and the
// contested-cycle count. Read returns are expected one cycle after a read
// grant: each cycle pushes what the next cycle should show, and the next cycle
// pops it. The RAM is modelled as a registered-address lookup table.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_req, host_wr, eng_req, eng_wr, eng_lock;
    logic [AW-1:0] host_addr, eng_addr;
    logic [DW-1:0] host_wdata, eng_wdata;
    logic          host_grant, eng_grant, host_rvalid, eng_rvalid;
    logic [DW-1:0] host_rdata, eng_rdata;
    logic [AW-1:0] ram_rdaddress, ram_wraddress;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_wren;
    logic [15:0]   conflict_count;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(16)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .eng_req(eng_req), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_lock(eng_lock),
        .host_grant(host_grant), .eng_grant(eng_grant),
        .host_rvalid(host_rvalid), .eng_rvalid(eng_rvalid),
        .host_rdata(host_rdata), .eng_rdata(eng_rdata),
        .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .conflict_count(conflict_count)
    );

    // RAM model: contents are a fixed function of the address.
    function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
        return (a == 14'h0005) ? 32'hDEADBEEF : (32'hC0DE0000 | {18'b0, a});
    endfunction

    logic [AW-1:0] ram_addr_r = '0;
    always @(posedge clk) ram_addr_r <= ram_rdaddress;
    assign ram_q = ram_f(ram_addr_r);

    // ---------------------------------------------------------------------
    // Checking infrastructure
    // ---------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          hr, hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          er, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          el;
        logic          xh, xe;   // expected grants
    } vec_t;

    typedef struct {
        logic          hv, ev;
        logic [DW-1:0] d;
    } ret_t;

    ret_t sb[$];

    // Bench-side expectations of held values
    logic [AW-1:0] exp_rdaddr = '0, exp_wraddr = '0;
    logic [DW-1:0] exp_data = '0, exp_hrdata = '0, exp_erdata = '0;
    logic [15:0]   exp_cc = '0;

    function automatic vec_t mk(input logic hr, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                                input logic er, ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                                input logic el, xh, xe);
        vec_t v;
        v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
        v.el = el; v.xh = xh; v.xe = xe;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic run_cycle(input vec_t v, input logic rst, input string tag);
        ret_t          e;
        logic          g_wr, g_rd;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_data;
        logic [AW-1:0] x_rd, x_wr;
        logic [DW-1:0] x_data;

        reset = rst;
        host_req = v.hr; host_wr = v.hw; host_addr = v.ha; host_wdata = v.hd;
        eng_req = v.er;  eng_wr = v.ew;  eng_addr = v.ea;  eng_wdata = v.ed;
        eng_lock = v.el;
        @(negedge clk);

        g_wr   = v.xh ? v.hw : v.ew;
        g_addr = v.xh ? v.ha : v.ea;
        g_data = v.xh ? v.hd : v.ed;
        g_rd   = (v.xh | v.xe) & ~g_wr;
        x_rd   = g_rd ? g_addr : exp_rdaddr;
        x_wr   = ((v.xh | v.xe) & g_wr) ? g_addr : exp_wraddr;
        x_data = ((v.xh | v.xe) & g_wr) ? g_data : exp_data;

        check({tag, " host_grant"}, {31'b0, host_grant}, {31'b0, v.xh});
        check({tag, " eng_grant"},  {31'b0, eng_grant},  {31'b0, v.xe});
        check({tag, " ram_wren"},   {31'b0, ram_wren},   {31'b0, (v.xh | v.xe) & g_wr});
        check({tag, " ram_rdaddress"}, {18'b0, ram_rdaddress}, {18'b0, x_rd});
        check({tag, " ram_wraddress"}, {18'b0, ram_wraddress}, {18'b0, x_wr});
        check({tag, " ram_data"},   ram_data, x_data);
        check({tag, " conflict_count"}, {16'b0, conflict_count}, {16'b0, exp_cc});

        e = '{hv: 1'b0, ev: 1'b0, d: '0};
        if (sb.size() > 0) e = sb.pop_front();
        if (rst) begin
            e.hv = 1'b0;
            e.ev = 1'b0;
        end
        check({tag, " host_rvalid"}, {31'b0, host_rvalid}, {31'b0, e.hv});
        check({tag, " eng_rvalid"},  {31'b0, eng_rvalid},  {31'b0, e.ev});
        check({tag, " host_rdata"},  host_rdata, e.hv ? e.d : exp_hrdata);
        check({tag, " eng_rdata"},   eng_rdata,  e.ev ? e.d : exp_erdata);
        if (e.hv) exp_hrdata = e.d;
        if (e.ev) exp_erdata = e.d;

        // Advance the bench model to the state after this edge
        if (rst) begin
            exp_cc = '0; exp_rdaddr = '0; exp_wraddr = '0; exp_data = '0;
            exp_hrdata = '0; exp_erdata = '0;
            sb.push_back('{hv: 1'b0, ev: 1'b0, d: '0});
        end else begin
            if (v.hr && v.er && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
            exp_rdaddr = x_rd;
            exp_wraddr = x_wr;
            exp_data   = x_data;
            sb.push_back('{hv: v.xh & g_rd, ev: v.xe & g_rd, d: ram_f(g_addr)});
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[11];
    vec_t v;

    initial begin
        reset = 1'b1;
        host_req = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
        eng_req = 0;  eng_wr = 0;  eng_addr = '0;  eng_wdata = '0;
        eng_lock = 0;

        //           hr hw ha       hd            er ew ea       ed            el xh xe
        tbl[0]  = mk(1, 0, 14'h0005, 32'h0,        0, 0, 14'h0,   32'h0,        0, 1, 0); // host read
        tbl[1]  = mk(0, 0, 14'h0,    32'h0,        0, 0, 14'h0,   32'h0,        0, 0, 0); // idle
        tbl[2]  = mk(1, 0, 14'h0010, 32'h0,        1, 0, 14'h0020, 32'h0,       0, 1, 0); // contested x4
        tbl[3]  = mk(1, 0, 14'h0011, 32'h0,        1, 0, 14'h0021, 32'h0,       0, 0, 1);
        tbl[4]  = mk(1, 0, 14'h0012, 32'h0,        1, 0, 14'h0022, 32'h0,       0, 1, 0);
        tbl[5]  = mk(1, 0, 14'h0013, 32'h0,        1, 0, 14'h0023, 32'h0,       0, 0, 1);
        tbl[6]  = mk(0, 0, 14'h0,    32'h0,        1, 1, 14'h0100, 32'h12345678, 0, 0, 1); // eng write
        tbl[7]  = mk(0, 0, 14'h0,    32'h0,        0, 0, 14'h0,   32'h0,        0, 0, 0);
        tbl[8]  = mk(1, 1, 14'h0200, 32'hAAAA5555, 1, 0, 14'h0030, 32'h0,       0, 1, 0); // host wr vs eng rd
        tbl[9]  = mk(1, 1, 14'h0201, 32'h11112222, 1, 1, 14'h0301, 32'h33334444, 0, 0, 1); // both write
        tbl[10] = mk(0, 0, 14'h0,    32'h0,        0, 0, 14'h0,   32'h0,        0, 0, 0);

        @(posedge clk);
        #1;
        // Requests during reset must not be granted
        run_cycle(mk(1, 0, 14'h7, 32'h0, 1, 0, 14'h8, 32'h0, 1, 0, 0), 1'b1, "reset");

        for (int i = 0; i < 11; i++) run_cycle(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Lock burst: host wins the first contested cycle, then 16 engine
        // grants, one host grant in cooldown, then the engine relocks.
        for (int i = 0; i < 20; i++) begin
            v = mk(1, 0, 14'h0040 + 14'(i), 32'h0, 1, 0, 14'h0080 + 14'(i), 32'h0, 1,
                   (i == 0 || i == 17), !(i == 0 || i == 17));
            run_cycle(v, 1'b0, $sformatf("lock%0d", i));
        end
        run_cycle(tbl[10], 1'b0, "unlock");

        // Reset arriving with a host read: no rvalid afterwards, count cleared,
        // host wins the first contested cycle again.
        run_cycle(mk(1, 0, 14'h0005, 32'h0, 0, 0, 14'h0, 32'h0, 0, 0, 0), 1'b1, "rst_rd");
        run_cycle(mk(1, 0, 14'h0006, 32'h0, 1, 0, 14'h0007, 32'h0, 1, 1, 0), 1'b0, "post_rst");
        run_cycle(tbl[10], 1'b0, "post_rst_idle");

        // Saturation of the contested-cycle counter
        host_req = 1; host_wr = 0; eng_req = 1; eng_wr = 0; eng_lock = 0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("conflict_sat", {16'b0, conflict_count}, 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        check("conflict_hold", {16'b0, conflict_count}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Shares the single board RAM (32-bit data, registered address, 1-cycle read latency) between the software host port and the hardware move engine.

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, RAM word address width.
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive engine lock cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports host_req / eng_req  input  1  access request.
REQ-007 SHALL have ports host_wr / eng_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports host_addr / eng_addr  input  ADDR_WIDTH  word address.
REQ-009 SHALL have ports host_wdata / eng_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port eng_lock  input  1  engine requests back-to-back ownership.
REQ-011 SHALL have ports host_grant / eng_grant  output  1  access accepted this cycle (combinational).
REQ-012 SHALL have ports host_rvalid / eng_rvalid  output  1  read data valid (registered).
REQ-013 SHALL have ports host_rdata / eng_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have ports ram_rdaddress / ram_wraddress  output  ADDR_WIDTH  RAM addresses.
REQ-015 SHALL have port ram_data  output  DATA_WIDTH  RAM write data.
REQ-016 SHALL have port ram_wren  output  1  RAM write enable.
REQ-017 SHALL have port ram_q  input  DATA_WIDTH  RAM read data, valid one cycle after address.
REQ-018 SHALL have port conflict_count  output  16  count of contested cycles, saturating.

Function
REQ-019 SHALL assert at most one grant per cycle; grant only when that requester's req=1.
REQ-020 SHALL, with a single requester, grant it in the same cycle.
REQ-021 SHALL, when both request and no lock is active, grant the port that lost the previous contested cycle (round-robin).
REQ-022 SHALL drive the granted port's addr/wdata onto ram_wraddress/ram_data with ram_wren=1 for a write; ram_rdaddress for a read.
REQ-023 SHALL hold ram_rdaddress/ram_wraddress at their previous values and ram_wren=0 when nothing is granted.
REQ-024 SHALL assert the owner's rvalid exactly one cycle after a read grant, rdata = ram_q that cycle; rdata of the other port holds its previous value.
REQ-025 SHALL never assert rvalid for a write grant.
REQ-026 SHALL enter LOCKED when eng_grant=1 with eng_lock=1; states IDLE, LOCKED, COOLDOWN.
REQ-027 SHALL, in LOCKED, grant the engine whenever eng_req=1 regardless of host_req; lock counter increments per engine grant.
REQ-028 SHALL leave LOCKED to IDLE when eng_lock=0 or eng_req=0.
REQ-029 SHALL leave LOCKED to COOLDOWN after MAX_LOCK consecutive engine grants; in COOLDOWN engine is not granted while host_req=1.
REQ-030 SHALL leave COOLDOWN to IDLE after one host grant, or immediately if host_req=0.
REQ-031 SHALL increment conflict_count on every cycle with host_req=1 and eng_req=1; saturate at 0xFFFF.
REQ-032 SHALL treat simultaneous read and write requests identically (no read/write priority).

Reset
REQ-033 SHALL, while reset=1, force grants=0, ram_wren=0, both rvalid=0, state IDLE, lock counter=0, conflict_count=0.
REQ-034 SHALL reset round-robin history so the host wins the first contested cycle.
REQ-035 SHALL suppress rvalid in the cycle after reset deasserts even if a read was granted in the reset cycle.
REQ-036 SHALL reset rdata outputs and RAM address outputs to 0.

Verification
REQ-037 Host-only read addr 0x0005, RAM returns 0xDEADBEEF -> host_grant same cycle, host_rvalid next cycle, host_rdata=0xDEADBEEF, eng_rvalid=0.
REQ-038 Both request reads for 4 cycles after reset -> grants host, eng, host, eng; conflict_count=4.
REQ-039 Engine write addr 0x0100 data 0x12345678 -> ram_wren=1, ram_wraddress=0x0100, ram_data=0x12345678, no rvalid.
REQ-040 eng_lock=1, both requesting 20 cycles, MAX_LOCK=16 -> 16 engine grants, then host grant, then engine relocks.
REQ-041 Reset asserted in the cycle of a host read grant -> host_rvalid=0 next cycle, conflict_count=0, state IDLE.
REQ-042 conflict_count preloaded near 0xFFFF by 70000 contested cycles -> holds 0xFFFF.
